// File: rtl/obstacle_guard.sv
// obstacle_guard
//   Consumes distance samples from the ultrasonic ranging stage, smooths them
//   with a power-of-two moving average, makes a hysteretic, confirmed
//   "obstacle near" decision, watches for a stale sensor and gates the motor
//   enables accordingly.
//
// Ports
//   clk              system clock
//   rst              asynchronous, active-high reset
//   dist_valid       one-cycle strobe qualifying dist_cm
//   dist_cm[19:0]    distance sample in cm
//   start_move       request both wheels
//   start_left_move  request left wheel
//   start_right_move request right wheel
//   avg_cm[19:0]     current moving average (holds between updates)
//   avg_valid        one-cycle strobe when avg_cm updates
//   near             1 = obstacle, motors stopped
//   timeout          sensor considered stale
//   en_left/en_right motor enables
module obstacle_guard #(
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned NEAR_CM     = 30,
  parameter int unsigned FAR_CM      = 35,
  parameter int unsigned CONFIRM     = 3,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned TIMEOUT_CYC = 20000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dist_valid,
  input  logic [19:0] dist_cm,
  input  logic        start_move,
  input  logic        start_left_move,
  input  logic        start_right_move,
  output logic [19:0] avg_cm,
  output logic        avg_valid,
  output logic        near,
  output logic        timeout,
  output logic        en_left,
  output logic        en_right
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = 20 + AVG_LOG2;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;

  localparam logic [19:0]       MAX_V   = 20'(MAX_CM);
  localparam logic [19:0]       NEAR_V  = 20'(NEAR_CM);
  localparam logic [19:0]       FAR_V   = 20'(FAR_CM);
  localparam logic [3:0]        CONF_V  = 4'(CONFIRM);
  localparam logic [FILL_W-1:0] FULL_V  = FILL_W'(DEPTH);
  localparam logic [31:0]       WD_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_CLEAR,
    S_BLOCKED,
    S_STALE
  } state_t;

  state_t              r_state;
  logic [19:0]         r_buf [DEPTH];
  logic [SUM_W-1:0]    r_sum;
  logic [FILL_W-1:0]   r_fill;
  logic [AVG_LOG2-1:0] r_wptr;
  logic [19:0]         r_avg;
  logic                r_avg_valid;
  logic                r_near;
  logic                r_timeout;
  logic [3:0]          r_cnt;
  logic [31:0]         r_wd;

  logic [19:0]         w_clamped;
  logic                w_full;
  logic [19:0]         w_evict;
  logic [SUM_W-1:0]    w_sum_next;
  logic [FILL_W-1:0]   w_fill_next;
  logic                w_expire;
  logic [3:0]          w_cnt_inc;

  assign w_clamped   = (dist_cm > MAX_V) ? MAX_V : dist_cm;
  assign w_full      = (r_fill == FULL_V);
  // Nothing is evicted until the window has been completely filled.
  assign w_evict     = w_full ? r_buf[r_wptr] : '0;
  assign w_sum_next  = r_sum + SUM_W'(w_clamped) - SUM_W'(w_evict);
  assign w_fill_next = w_full ? FULL_V : r_fill + 1'b1;
  // A sample arriving on the last watchdog cycle wins over the expiry.
  assign w_expire    = (r_state != S_STALE) && !dist_valid && (r_wd == WD_LAST);
  assign w_cnt_inc   = r_cnt + 4'd1;

  // Averaging datapath: ring buffer, running sum and registered average.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_sum       <= '0;
      r_fill      <= '0;
      r_wptr      <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (w_expire) begin
        // Stale sensor: drop the whole window so old data never mixes in.
        for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        r_sum  <= '0;
        r_fill <= '0;
        r_wptr <= '0;
      end else if (dist_valid) begin
        r_buf[r_wptr] <= w_clamped;
        r_sum         <= w_sum_next;
        r_wptr        <= r_wptr + 1'b1;
        r_fill        <= w_fill_next;
        if (w_fill_next == FULL_V) begin
          r_avg       <= w_sum_next[AVG_LOG2 +: 20];
          r_avg_valid <= 1'b1;
        end
      end
    end
  end

  // Decision FSM with watchdog; near/timeout are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FILL;
      r_near    <= 1'b1;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_wd      <= '0;
    end else begin
      if (dist_valid) begin
        r_wd <= '0;
      end else if (!w_expire && r_state != S_STALE) begin
        r_wd <= r_wd + 32'd1;
      end

      if (w_expire) begin
        r_state   <= S_STALE;
        r_near    <= 1'b1;
        r_timeout <= 1'b1;
        r_cnt     <= '0;
      end else begin
        case (r_state)
          S_FILL: begin
            if (r_avg_valid) begin
              if (r_avg > NEAR_V) begin
                r_state <= S_CLEAR;
                r_near  <= 1'b0;
              end else begin
                r_state <= S_BLOCKED;
                r_near  <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            if (r_avg_valid) begin
              if (r_avg <= NEAR_V) begin
                if (w_cnt_inc == CONF_V) begin
                  r_state <= S_BLOCKED;
                  r_near  <= 1'b1;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= w_cnt_inc;
                end
              end else begin
                r_cnt <= '0;
              end
            end
          end
          S_BLOCKED: begin
            if (r_avg_valid) begin
              if (r_avg >= FAR_V) begin
                if (w_cnt_inc == CONF_V) begin
                  r_state <= S_CLEAR;
                  r_near  <= 1'b0;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= w_cnt_inc;
                end
              end else begin
                r_cnt <= '0;
              end
            end
          end
          S_STALE: begin
            // The sample itself is written as entry 0 by the datapath.
            if (dist_valid) begin
              r_state   <= S_FILL;
              r_timeout <= 1'b0;
            end
          end
          default: begin
            r_state <= S_FILL;
            r_near  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign avg_cm    = r_avg;
  assign avg_valid = r_avg_valid;
  assign near      = r_near;
  assign timeout   = r_timeout;
  assign en_left   = !r_near & (start_move | start_left_move);
  assign en_right  = !r_near & (start_move | start_right_move);

endmodule

// File: doc/obstacle_guard.md
Name: obstacle_guard

Overview:
- Downstream consumer of the ultrasonic ranging stage. Takes each new distance sample (cm) from it.
- Smooths samples with a power-of-two moving average.
- Decides "obstacle near" with hysteresis and N-sample confirmation, and runs a watchdog for a missing or dead sensor.
- Drives the motor enables. It replaces the raw threshold compare currently feeding the motor driver.

Parameters:
- AVG_LOG2, 2: log2 of moving-average depth (depth = 4).
- NEAR_CM, 30: block threshold; avg_cm <= NEAR_CM counts as near.
- FAR_CM, 35: release threshold; avg_cm >= FAR_CM counts as far. Must be > NEAR_CM.
- CONFIRM, 3: consecutive qualifying averages required to change the decision (1..15).
- MAX_CM, 400: input clamp value.
- TIMEOUT_CYC, 20000000: watchdog period in clk cycles (200 ms at 100 MHz).

Ports:
- clk, input, 1: 100 MHz system clock.
- rst, input, 1: reset, asynchronous, active-high.
- dist_valid, input, 1: one-cycle strobe marking a new sample, clk domain.
- dist_cm, input, 20: sample value, qualified by dist_valid.
- start_move, input, 1: drive both wheels.
- start_left_move, input, 1: drive left wheel.
- start_right_move, input, 1: drive right wheel.
- avg_cm, output, 20: current moving average.
- avg_valid, output, 1: one-cycle strobe when avg_cm updates.
- near, output, 1: obstacle-blocked decision (1 = stop).
- timeout, output, 1: watchdog expired; sensor considered stale.
- en_left, output, 1: left motor enable.
- en_right, output, 1: right motor enable.

Behaviour:
- Reset values (asynchronous):
  - Outputs: avg_cm=0, avg_valid=0, near=1, timeout=0.
  - Internal: buffer contents 0, running sum 0, fill count 0, write pointer 0, confirm counter 0, watchdog 0, state FILL.
- Sample accept: every cycle with dist_valid=1. Back-to-back strobes are legal and each is accepted.
  - Clamp: value = min(dist_cm, MAX_CM).
  - Written into a 2^AVG_LOG2-entry ring buffer at the write pointer. The pointer wraps from 2^AVG_LOG2-1 to 0.
  - Running sum (20+AVG_LOG2 bits) updates as sum + new - evicted entry. The evicted entry is 0 while filling.
- Averaging:
  - avg_cm = sum >> AVG_LOG2 (truncating), registered.
  - avg_valid pulses exactly one cycle after an accepted sample, only once the buffer is full (fill count = 2^AVG_LOG2).
  - avg_cm holds its value between strobes.
- States: FILL, CLEAR, BLOCKED, STALE. The decision is evaluated in the cycle avg_valid=1, using the new avg_cm. near updates on the following edge, so latency is 2 cycles from dist_valid.
  - FILL: near=1. On the first avg_valid, go to CLEAR (near=0) if avg_cm > NEAR_CM, else BLOCKED. No confirmation applies.
  - CLEAR: on each avg_valid, if avg_cm <= NEAR_CM then increment the confirm counter, else zero it. When the counter reaches CONFIRM, go to BLOCKED, set near=1, zero the counter.
  - BLOCKED: on each avg_valid, if avg_cm >= FAR_CM then increment the confirm counter, else zero it. When it reaches CONFIRM, go to CLEAR, set near=0, zero the counter. Values in NEAR_CM < avg < FAR_CM zero the counter.
  - STALE: near=1, timeout=1. Entered from any state when the watchdog reaches TIMEOUT_CYC-1 with no dist_valid.
    - Entry flushes fill count, sum, buffer and pointer to 0, and zeroes the confirm counter.
    - The next accepted sample clears timeout, goes to FILL, and becomes buffer entry 0.
- Watchdog:
  - Zeroed on every accepted sample; otherwise increments.
  - Saturates (holds) in STALE.
  - If dist_valid arrives in the cycle the watchdog would expire, the sample wins: no timeout.
- Motor enables (combinational from registered near):
  - en_left = !near & (start_move | start_left_move).
  - en_right = !near & (start_move | start_right_move).
  - Both are 0 during reset, FILL and STALE.
- Reset mid-operation discards all samples and the state. Behaviour after reset is identical to power-up.

Test Plan:
- Reset, then 4 samples of 100 cm, one every 10 cycles -> avg_valid once, 1 cycle after the 4th; avg_cm=100; near falls 0 after that; with start_move=1, en_left=en_right=1. No avg_valid after samples 1-3.
- From CLEAR at avg 100: feed 20 cm samples -> averages 80, 60, 40, 20, 20, 20; near rises only after the 3rd average <= 30 (6th sample); en_left/en_right drop with it.
- Hysteresis: from BLOCKED at avg 20, feed 32 cm until the average settles at 32 -> near stays 1. Then feed 40 cm -> near clears after the 3rd average >= 35. Alternating 36/28 averages -> counter keeps zeroing and near never changes.
- Clamp/width: samples of 20'hFFFFF -> avg_cm=400, no overflow. Sum of 4x400 is 1600, checked exactly.
- Watchdog with TIMEOUT_CYC=1000: stop strobes -> timeout=1 and near=1 exactly 1000 cycles after the last sample. Next sample -> timeout=0, state FILL, no avg_valid until 4 new samples; the average excludes old data. A strobe landing on cycle 999 -> no timeout.
- Back-to-back dist_valid for 8 cycles at 50, 50, 50, 50, 10, 10, 10, 10 -> avg_valid every cycle from cycle 5. avg_cm sequence: 50, 40, 30, 20, 10.
- Async rst asserted mid-BLOCKED with no clock edge -> all outputs at reset values immediately.
